// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shared sprite/tile ROM arbiter with optional absolute priority for requester 0
// Round-robin grant, registered ROM address, and an ID pipeline that returns ROM data to the winner.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1,
  parameter int PRIO0   = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic [ROM_LAT-1:0] r_pipe_v;
  logic [PTR_W-1:0]   r_pipe_id [ROM_LAT];

  logic               w_found;
  logic               w_override;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_ret;
  logic [ADDR_W-1:0]  w_win_addr;

  // Wrap is modulo NUM_REQ, not 2^PTR_W, so non-power-of-two counts rotate correctly.
  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NUM_REQ;
  endfunction

  always_comb begin
    w_found    = 1'b0;
    w_override = 1'b0;
    w_win      = '0;
    w_gnt      = '0;
    w_win_addr = '0;
    if (PRIO0 != 0 && req[0]) begin
      w_found    = 1'b1;
      w_override = 1'b1;
      w_gnt[0]   = 1'b1;
      w_win_addr = addr[ADDR_W-1:0];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!w_found && req[wrap_idx(int'(r_ptr), k)]) begin
          w_found = 1'b1;
          w_win   = PTR_W'(wrap_idx(int'(r_ptr), k));
          w_gnt[wrap_idx(int'(r_ptr), k)] = 1'b1;
          w_win_addr = addr[wrap_idx(int'(r_ptr), k)*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  always_comb begin
    w_ret = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pipe_id[ROM_LAT-1] == PTR_W'(i)) w_ret[i] = 1'b1;
    end
  end

  // Registered grant covers the cycle the read is issued; pipeline bits cover the rest.
  assign busy = (|r_pipe_v) | (|gnt);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      gnt         <= '0;
      rom_address <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      r_ptr       <= PTR_W'(NUM_REQ - 1);
      r_pipe_v    <= '0;
      for (int j = 0; j < ROM_LAT; j++) r_pipe_id[j] <= '0;
    end else begin
      gnt <= w_gnt;
      if (w_found) begin
        rom_address <= w_win_addr;
        if (!w_override) r_ptr <= w_win;
      end
      r_pipe_v[0]  <= w_found;
      r_pipe_id[0] <= w_win;
      for (int j = 1; j < ROM_LAT; j++) begin
        r_pipe_v[j]  <= r_pipe_v[j-1];
        r_pipe_id[j] <= r_pipe_id[j-1];
      end
      rvalid <= r_pipe_v[ROM_LAT-1] ? w_ret : '0;
      if (r_pipe_v[ROM_LAT-1]) rdata <= rom_q;
    end
  end

endmodule
